// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared constants and helpers for the
// direct-mapped write-through cache controller.
package dm_cache_pkg;

    localparam int ADDR_W_D  = 16;
    localparam int INDEX_W_D = 4;
    localparam int DATA_W_D  = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    function automatic logic [31:0] line_index(
        input logic [31:0] addr,
        input int unsigned iw
    );
        return addr & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] line_tag(
        input logic [31:0] addr,
        input int unsigned iw
    );
        return addr >> iw;
    endfunction

endpackage

// File: rtl/dm_line_store.sv
// dm_line_store: tag/valid/data arrays, async read,
// sync write, bulk and async valid clear.
module dm_line_store
    import dm_cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_D,
    parameter int TAG_W   = ADDR_W_D - INDEX_W_D,
    parameter int DATA_W  = DATA_W_D
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               i_inv,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_idx,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [DATA_W-1:0]  o_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: async clear on reset, bulk clear, set on fill
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_valid <= '0;
        end else if (i_inv) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until valid
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_data;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_data  = r_data[i_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: write-through, no-write-allocate cache
// controller with memory req/ack refill and hit counter.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int INDEX_W = INDEX_W_D,
    parameter int DATA_W  = DATA_W_D
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    input  logic              cache_inv,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [15:0]        r_hits;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [DATA_W-1:0]  w_line_data;
    logic               w_hit;
    logic               w_inv;
    logic               w_accept;
    logic               w_st_we;
    logic [DATA_W-1:0]  w_st_data;
    logic               w_mem_act;

    assign w_idx = INDEX_W'(line_index(32'(r_addr), INDEX_W));
    assign w_tag = TAG_W'(line_tag(32'(r_addr), INDEX_W));

    assign w_hit     = w_line_valid && (w_line_tag == w_tag);
    assign w_inv     = (r_state == S_IDLE) && cache_inv;
    assign w_accept  = (r_state == S_IDLE) && !cache_inv
                       && cpu_req;
    // Write hits rewrite the same tag, so one fill port suffices
    assign w_st_we   = ((r_state == S_LOOKUP) && r_we && w_hit)
                       || ((r_state == S_MEM_RD) && mem_ack);
    assign w_st_data = (r_state == S_MEM_RD) ? mem_rdata : r_wdata;

    dm_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_store (
        .clk     (clk),
        .clr     (clr),
        .i_inv   (w_inv),
        .i_we    (w_st_we),
        .i_idx   (w_idx),
        .i_tag   (w_tag),
        .i_data  (w_st_data),
        .o_valid (w_line_valid),
        .o_tag   (w_line_tag),
        .o_data  (w_line_data)
    );

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (r_we)       w_next = S_MEM_WR;
                else if (w_hit) w_next = S_RESP;
                else            w_next = S_MEM_RD;
            end
            S_MEM_RD: if (mem_ack) w_next = S_RESP;
            S_MEM_WR: if (mem_ack) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, request latches, read data and hit counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hits  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if ((r_state == S_LOOKUP) && !r_we && w_hit)
                r_rdata <= w_line_data;
            else if ((r_state == S_MEM_RD) && mem_ack)
                r_rdata <= mem_rdata;
            if ((r_state == S_LOOKUP) && w_hit
                && (r_hits != 16'hFFFF))
                r_hits <= r_hits + 16'd1;
        end
    end

    assign w_mem_act = (r_state == S_MEM_RD)
                       || (r_state == S_MEM_WR);

    assign cpu_rdata = r_rdata;
    assign cpu_done  = (r_state == S_RESP);
    assign cpu_busy  = (r_state != S_IDLE);
    assign mem_req   = w_mem_act;
    assign mem_we    = (r_state == S_MEM_WR);
    assign mem_addr  = w_mem_act ? r_addr : '0;
    assign mem_wdata = (r_state == S_MEM_WR) ? r_wdata : '0;
    assign hit_count = r_hits;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed and random accesses checked
// against an array-based cache model.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic        cache_inv;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] hit_count;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_valid [16];
    logic [11:0] m_tag   [16];
    logic [15:0] m_data  [16];
    int          m_hits;
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .cache_inv (cache_inv),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_hits  = 0;
        m_rdata = 16'h0000;
    endtask

    task automatic do_access(input logic        we,
                             input logic [15:0] addr,
                             input logic [15:0] wd,
                             input logic [15:0] rv,
                             input int          w,
                             input logic        inv);
        int          cyc;
        int          nreq;
        int          wc;
        bit          hit;
        bit          exp_mem;
        bit          done;
        logic [3:0]  idx;
        logic [11:0] tg;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cache_inv = inv;
        mem_rdata = rv;
        if (inv) begin
            @(negedge clk);
            check("inv_holds_idle", cpu_busy, 0);
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            cache_inv = 1'b0;
        end
        idx = addr[3:0];
        tg  = addr[15:4];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_mem = we || !hit;
        cyc  = 0;
        nreq = 0;
        wc   = 0;
        done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            cpu_req = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                nreq++;
                check("mem_we", mem_we, we);
                check("mem_addr", mem_addr, addr);
                if (we) check("mem_wdata", mem_wdata, wd);
                if (wc == w) mem_ack = 1'b1;
                else wc++;
            end
            if (cpu_done) done = 1;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", cyc, exp_mem ? 3 + w : 2);
            check("mem_req_cycles", nreq, exp_mem ? w + 1 : 0);
            if (hit && m_hits < 16'hFFFF) m_hits++;
            if (!we) begin
                if (hit) begin
                    m_rdata = m_data[idx];
                end else begin
                    m_valid[idx] = 1;
                    m_tag[idx]   = tg;
                    m_data[idx]  = rv;
                    m_rdata      = rv;
                end
            end else if (hit) begin
                m_data[idx] = wd;
            end
            check("cpu_rdata", cpu_rdata, m_rdata);
            check("hit_count", hit_count, m_hits);
        end
    endtask

    initial begin
        logic        r_we;
        logic [15:0] r_addr;
        logic [15:0] r_wd;
        logic [15:0] r_rv;
        logic [1:0]  r_tg;
        logic [3:0]  r_ix;
        clr       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cache_inv = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_done", cpu_done, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hits", hit_count, 0);
        check("rst_maddr", mem_addr, 0);
        clr = 1'b1;

        do_access(0, 16'h0123, 16'h0, 16'hBEEF, 3, 0);
        check("cold_rdata", cpu_rdata, 16'hBEEF);
        do_access(0, 16'h0123, 16'h0, 16'h0, 0, 0);
        check("hit_rdata", cpu_rdata, 16'hBEEF);
        check("hit_cnt1", hit_count, 1);
        do_access(1, 16'h0123, 16'h1234, 16'h0, 1, 0);
        do_access(0, 16'h0123, 16'h0, 16'h0, 0, 0);
        check("wr_rd_data", cpu_rdata, 16'h1234);
        check("hit_cnt3", hit_count, 3);
        do_access(0, 16'h0113, 16'h0, 16'h5555, 2, 0);
        do_access(0, 16'h0123, 16'h0, 16'h7777, 0, 0);
        do_access(1, 16'h0456, 16'hAAAA, 16'h0, 2, 0);
        do_access(0, 16'h0456, 16'h0, 16'h4567, 1, 0);
        do_access(0, 16'h0010, 16'h0, 16'h1010, 0, 0);
        do_access(0, 16'h0000, 16'h0, 16'h0F0F, 0, 0);
        do_access(0, 16'h0123, 16'h0, 16'h2222, 1, 1);
        do_access(0, 16'h0456, 16'h0, 16'h3333, 0, 0);

        do_access(0, 16'h0456, 16'h0, 16'h0, 0, 0);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0789;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        #2 clr = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_busy", cpu_busy, 0);
        check("mid_rst_hits", hit_count, 0);
        check("mid_rst_rdata", cpu_rdata, 0);
        model_reset();
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        clr     = 1'b1;
        @(negedge clk);
        check("late_ack_busy", cpu_busy, 0);
        do_access(0, 16'h0789, 16'h0, 16'h6789, 1, 0);
        do_access(0, 16'h0456, 16'h0, 16'h1111, 0, 0);

        for (int n = 0; n < 300; n++) begin
            r_we   = ($urandom_range(0, 2) == 0);
            r_tg   = 2'($urandom_range(0, 3));
            r_ix   = 4'($urandom_range(0, 15));
            r_addr = {10'h000, r_tg, r_ix};
            r_wd   = 16'($urandom);
            r_rv   = 16'($urandom);
            do_access(r_we, r_addr, r_wd, r_rv,
                      $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Controller side of the direct-mapped cache: accepts CPU word read/write requests, drives the line store (tag, valid, data), and refills from main memory over a req/ack handshake.
- Write-through, no write-allocate, one word per line.
- Sits between the CPU datapath and the memory port.
- Also holds a hit counter used by the debug readout.

Parameters:
- ADDR_W, 16, CPU/memory word address width.
- INDEX_W, 4, line index width; 2**INDEX_W lines.
- TAG_W, ADDR_W-INDEX_W (12), stored tag width; derived, never overridden.
- DATA_W, 16, word width.

Ports:
- clk  in  1  Clock; all state updates on rising edge.
- clr  in  1  Reset, asynchronous, active-low.
- cpu_req  in  1  Request valid; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
- cpu_addr  in  ADDR_W  Word address; index = [INDEX_W-1:0], tag = upper bits.
- cpu_wdata  in  DATA_W  Write data.
- cpu_rdata  out  DATA_W  Read data; valid while cpu_done is high.
- cpu_done  out  1  One-cycle completion pulse.
- cpu_busy  out  1  High in every state except IDLE.
- cache_inv  in  1  Invalidate all lines.
- mem_req  out  1  Memory request; held until mem_ack.
- mem_we  out  1  Memory write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_ack  in  1  Memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  Memory read data.
- hit_count  out  16  Saturating hit counter.

Behaviour:
- Reset (clr=0, async):
  - State goes to IDLE and all valid bits clear.
  - cpu_rdata, cpu_done, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata and hit_count all go to 0.
  - An in-flight mem_req drops immediately; a late mem_ack after reset is ignored.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - cache_inv=1 clears all valid bits in one cycle and stays in IDLE. It takes priority over a simultaneous cpu_req, which is accepted the next cycle.
  - cache_inv outside IDLE is ignored.
  - Otherwise cpu_req=1 latches cpu_we, cpu_addr and cpu_wdata, then moves to LOOKUP.
- LOOKUP: hit = valid[index] and tag[index] equals the address tag.
  - Read hit: cpu_rdata <= line data, hit_count increments, go to RESP.
  - Read miss: go to MEM_RD.
  - Write hit: line data <= wdata, hit_count increments, go to MEM_WR.
  - Write miss: line untouched, go to MEM_WR.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr = latched address.
  - On mem_ack: line <= {valid=1, tag, mem_rdata}, cpu_rdata <= mem_rdata, go to RESP.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata = latched values.
  - On mem_ack go to RESP.
- mem_req is asserted on the first cycle of MEM_RD/MEM_WR and deasserts the cycle after mem_ack. Address and data are stable while mem_req is high.
- RESP: cpu_done=1 for exactly one cycle, then IDLE.
  - cpu_rdata holds its value until the next read completes.
  - Writes leave cpu_rdata unchanged.
- Latency, accept edge to cpu_done high:
  - Read hit: 2 cycles.
  - Read miss or any write: 2 + memory wait cycles + 1.
- The earliest next accept is the IDLE cycle after RESP. The requester must deassert cpu_req on cpu_done or it is re-accepted.
- hit_count saturates at 16'hFFFF. Misses do not change it. It clears only on reset.
- Index wrap: address 16'h0010 maps to line 0, the same line as 16'h0000. A refill overwrites that line's tag.

Decomposition:
- Shared package dm_cache_pkg:
  - State encoding constants (IDLE=0 … RESP=4).
  - Default ADDR_W, INDEX_W, DATA_W.
  - Tag/index slice helper functions.
- Natural sub-module dm_line_store:
  - Tag, valid and data arrays.
  - Asynchronous read; synchronous write on rising clk.
  - Bulk valid clear input; async clear of valid on clr.
- Controller FSM, latches and hit counter stay in dm_cache_ctrl.

Test Plan:
- Cold read miss: after reset, read 16'h0123 with memory acking 3 cycles later with 16'hBEEF → one mem_req (mem_we=0, mem_addr=16'h0123); cpu_done with cpu_rdata=16'hBEEF; hit_count=0.
- Read hit: repeat read of 16'h0123 → no mem_req; cpu_done exactly 2 cycles after accept with 16'hBEEF; hit_count=1.
- Write hit then read: write 16'h0123←16'h1234 → mem write issued with mem_wdata=16'h1234; following read hits with 16'h1234; hit_count=3.
- Conflict and no-allocate:
  - Read 16'h0113 (same index 3) refills the line.
  - Read 16'h0123 misses again.
  - Write to 16'h0456 with line 6 invalid → mem write issued; a subsequent read of 16'h0456 misses.
- Invalidate: cache_inv and cpu_req asserted together in IDLE → request accepted one cycle later and misses; all previously valid lines miss.
- Reset mid-refill: drop clr while in MEM_RD → mem_req=0 and cpu_busy=0 immediately; a late mem_ack has no effect; the next read of that address misses.
